// File: rtl/musicbox_pkg.sv
// Shared definitions for the music-box song-memory dump path.
//   - FSM state enum for uart_dump_tx (SUM exists only when
//     UART_DUMP_CHECKSUM_EN is defined)
//   - song-memory word/address widths
//   - UART frame bit levels
//   - helpers that split a 12-bit word into the two transmitted bytes
package musicbox_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 16;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef UART_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HI, LO, SUM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HI, LO, FIN} state_t;
`endif

  // Upper nibble goes out first, zero-padded to a full byte.
  function automatic logic [7:0] hi_byte(input logic [WORD_W-1:0] w);
    return {4'b0000, w[11:8]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first.
// Parameter: DIV - clocks per bit (>= 1).
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load        accept data when ready is high
//   data[7:0]   byte to send
//   tx          registered serial line, idle high
//   ready       high when no frame is in progress (a load is accepted)
module uart_tx_byte
  import musicbox_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]       shifter;   // bits still to be shifted out after the current one

  assign ready = !active;

  // NOTE: asynchronous reset drives tx high immediately, so a frame is cut off
  // mid-bit without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '1;
      tx       <= STOP_BIT;
    end else if (!active) begin
      if (load) begin
        active   <= 1'b1;
        tx       <= START_BIT;
        shifter  <= {STOP_BIT, data};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        // Stop bit has been held a full bit time; tx is already high.
        active <= 1'b0;
      end else begin
        tx      <= shifter[0];
        shifter <= {STOP_BIT, shifter[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_dump_tx.sv
// Dumps len 12-bit song-memory words over a UART as two bytes per word
// ({4'b0, word[11:8]} then word[7:0]).
// Optional feature: define UART_DUMP_CHECKSUM_EN to append one byte holding
// the XOR of every byte sent in the dump (8'h00 for len == 0).
// Parameters: CLK_HZ (clock frequency), BAUD (bit rate); DIV = CLK_HZ/BAUD.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   start         one-cycle pulse, accepted only when idle
//   len[15:0]     word count, captured on accepted start
//   rd_addr[15:0] song-memory read address
//   rd_data[11:0] song-memory data, valid one cycle after rd_addr changes
//   tx            serial output, idle high
//   busy          high from accepted start until done
//   done          one-cycle pulse at dump completion
module uart_dump_tx
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int DIV = CLK_HZ / BAUD;

  state_t            state, state_d;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] len_q;
  logic [WORD_W-1:0] word;
  logic              load;
  logic [7:0]        tx_byte;
  logic              tx_ready;
  logic              more;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  // Widened compare so index+1 cannot wrap when len is 16'hFFFF.
  assign more = ({1'b0, index} + 17'd1) < {1'b0, len_q};
  assign busy = (state != IDLE) && !done;

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (tx_byte),
    .tx    (tx),
    .ready (tx_ready)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // HI/LO/SUM each hand a byte to the transmitter as soon as it is ready and
  // move on; the next word is fetched while the low byte is on the line, so
  // bytes leave back-to-back. FIN waits for the last stop bit before done.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    tx_byte = 8'h00;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) state_d = FETCH;
`ifdef UART_DUMP_CHECKSUM_EN
          else           state_d = SUM;
`else
          else           state_d = FIN;
`endif
        end
      end
      FETCH: state_d = WAIT;
      WAIT:  state_d = HI;
      HI: begin
        tx_byte = hi_byte(word);
        if (tx_ready) begin
          load    = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        tx_byte = lo_byte(word);
        if (tx_ready) begin
          load = 1'b1;
          if (more) state_d = FETCH;
`ifdef UART_DUMP_CHECKSUM_EN
          else      state_d = SUM;
`else
          else      state_d = FIN;
`endif
        end
      end
`ifdef UART_DUMP_CHECKSUM_EN
      SUM: begin
        tx_byte = checksum;
        if (tx_ready) begin
          load    = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        if (tx_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: rd_addr only moves when entering FETCH, so it holds elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      index    <= '0;
      rd_addr  <= '0;
      word     <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      checksum <= 8'h00;
`endif
    end else begin
      if (state == IDLE && start) begin
        len_q    <= len;
        index    <= '0;
        rd_addr  <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
        checksum <= 8'h00;
`endif
      end
      if (state == WAIT) word <= rd_data;
      if (state == LO && load && more) begin
        index   <= index + 16'd1;
        rd_addr <= index + 16'd1;
      end
`ifdef UART_DUMP_CHECKSUM_EN
      if (load && state != SUM) checksum <= checksum ^ tx_byte;
`endif
    end
  end

endmodule

// File: tb/tb_uart_dump_tx.sv
// Directed self-checking bench for uart_dump_tx at CLK_HZ=1600, BAUD=100
// (16 clocks per bit). A registered song-memory model answers rd_addr one
// clock later; a line sampler decodes frames on the falling clock edge and
// checks every bit is stable for its whole 16-clock window.
module tb_uart_dump_tx;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic [15:0] rd_addr;
  logic [11:0] rd_data = 12'h000;
  logic        tx, busy, done;

  logic [11:0] mem [0:15];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t_start = 0;

  uart_dump_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= mem[rd_addr[3:0]];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] l);
    @(negedge clk);
    len = l;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for a start bit, then takes 160 falling-edge samples (16 per bit).
  // Optionally pulses start at sample pulse_at to probe start-while-busy.
  task automatic recv_byte(input int pulse_at, output logic [7:0] b,
                           output logic stable, output logic got);
    logic [9:0] bits;
    got = 1'b0;
    stable = 1'b1;
    b = 8'h00;
    bits = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) return;
    for (int s = 0; s < 160; s++) begin
      if (s > 0) @(negedge clk);
      start = (s == pulse_at);
      if (s % 16 == 0) bits[s/16] = tx;
      else if (tx !== bits[s/16]) stable = 1'b0;
    end
    start = 1'b0;
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) stable = 1'b0;
    b = bits[8:1];
  endtask

  task automatic rx_check(input string tag, input logic [7:0] exp, input int pulse_at);
    logic [7:0] b;
    logic stable, got;
    recv_byte(pulse_at, b, stable, got);
    check({tag, "_frame_seen"}, got, 1'b1);
    if (got) begin
      check(tag, b, exp);
      check({tag, "_bit_timing"}, stable, 1'b1);
    end
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - t_start;
        break;
      end
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int lat, dc, txbad;
    logic [7:0] exp3 [0:5];
    logic [7:0] sum;

    foreach (mem[i]) mem[i] = 12'h000;

    // Reset values and quiet idle line.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_addr", rd_addr, 16'h0000);
    rst_n = 1'b1;
    idle_check("idle_100", 100);

    // One word: 12'hA5C -> 0A, 5C.
    mem[0] = 12'hA5C;
    dc = done_cnt;
    pulse_start(16'd1);
    check("len1_busy", busy, 1'b1);
    rx_check("len1_b0", 8'h0A, -1);
    rx_check("len1_b1", 8'h5C, -1);
`ifdef UART_DUMP_CHECKSUM_EN
    rx_check("len1_sum", 8'h0A ^ 8'h5C, -1);
    wait_done(20, lat);
    check("len1_done_seen", lat >= 0, 1'b1);
`else
    wait_done(20, lat);
    check("len1_done_seen", lat >= 0, 1'b1);
    check("len1_total_320_326", (lat >= 320) && (lat <= 326), 1'b1);
`endif
    @(negedge clk);
    check("len1_busy_after", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("len1_done_count", done_cnt - dc, 1);

    // Zero words.
    dc = done_cnt;
    txbad = 0;
    lat = -1;
    @(negedge clk);
    len = 16'd0;
    start = 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    rx_check("len0_sum", 8'h00, -1);
    wait_done(20, lat);
    check("len0_done_seen", lat >= 0, 1'b1);
    idle_check("len0_single_frame", 200);
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx !== 1'b1) txbad++;
      if (done === 1'b1 && lat < 0) lat = i + 1;
    end
    check("len0_done_within_3", lat > 0, 1'b1);
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) txbad++;
    end
    check("len0_tx_stays_high", txbad, 0);
`endif
    check("len0_done_count", done_cnt - dc, 1);

    // Three words.
    mem[0] = 12'h123;
    mem[1] = 12'h456;
    mem[2] = 12'hFFF;
    exp3[0] = 8'h01; exp3[1] = 8'h23; exp3[2] = 8'h04;
    exp3[3] = 8'h56; exp3[4] = 8'h0F; exp3[5] = 8'hFF;
    dc = done_cnt;
    pulse_start(16'd3);
    sum = 8'h00;
    for (int k = 0; k < 6; k++) begin
      rx_check($sformatf("len3_b%0d", k), exp3[k], -1);
      sum = sum ^ exp3[k];
    end
`ifdef UART_DUMP_CHECKSUM_EN
    rx_check("len3_sum", sum, -1);
`endif
    wait_done(20, lat);
    check("len3_done_seen", lat >= 0, 1'b1);
    check("len3_rd_addr_held", rd_addr, 16'd2);
    repeat (5) @(negedge clk);
    check("len3_done_count", done_cnt - dc, 1);

    // Start re-pulsed mid-dump with len changed to 9: must be ignored.
    dc = done_cnt;
    pulse_start(16'd2);
    len = 16'd9;
    rx_check("repulse_b0", 8'h01, 60);
    rx_check("repulse_b1", 8'h23, 100);
    rx_check("repulse_b2", 8'h04, -1);
    rx_check("repulse_b3", 8'h56, -1);
`ifdef UART_DUMP_CHECKSUM_EN
    rx_check("repulse_sum", 8'h01 ^ 8'h23 ^ 8'h04 ^ 8'h56, -1);
`endif
    wait_done(20, lat);
    check("repulse_done_seen", lat >= 0, 1'b1);
    idle_check("repulse_no_extra", 300);
    check("repulse_done_count", done_cnt - dc, 1);

    // Reset during data bit 4 of the first byte.
    mem[0] = 12'hA5C;
    dc = done_cnt;
    pulse_start(16'd1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = i;
        break;
      end
    end
    check("rstmid_frame_started", lat >= 0, 1'b1);
    repeat (88) @(negedge clk);
    check("rstmid_bit4_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_async", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check("rstmid_idle_after", 400);
    check("rstmid_no_done", done_cnt - dc, 0);
    pulse_start(16'd1);
    rx_check("rstmid_new_b0", 8'h0A, -1);
    rx_check("rstmid_new_b1", 8'h5C, -1);
`ifdef UART_DUMP_CHECKSUM_EN
    rx_check("rstmid_new_sum", 8'h0A ^ 8'h5C, -1);
`endif
    wait_done(20, lat);
    check("rstmid_new_done_seen", lat >= 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
